// File: rtl/gfc_pkg.sv
// rtl/gfc_pkg.sv - shared types, constants and BCD helper for game_flow_ctrl
package gfc_pkg;

    typedef enum logic [1:0] {
        TITLE     = 2'd0,
        PLAY      = 2'd1,
        INVULN    = 2'd2,
        GAME_OVER = 2'd3
    } gfc_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Two-digit BCD increment that saturates at 99; returns {tens, ones}.
    function automatic logic [7:0] bcd2_inc(input bcd_t tens, input bcd_t ones);
        if (tens == BCD_MAX && ones == BCD_MAX) begin
            return {tens, ones};
        end else if (ones == BCD_MAX) begin
            return {tens + 4'd1, 4'd0};
        end else begin
            return {tens, ones + 4'd1};
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter: first request at or after i_ptr wins
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic          o_valid,
    output logic [PW-1:0] o_idx
);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            // Wrap ptr+i back into 0..N-1 without a modulo so non-power-of-2 N works.
            w_sum = {1'b0, i_ptr} + (PW + 1)'(i);
            if (w_sum >= (PW + 1)'(N)) begin
                w_sum = w_sum - (PW + 1)'(N);
            end
            w_idx = w_sum[PW-1:0];
            if (!o_valid && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_valid        = 1'b1;
                o_idx          = w_idx;
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - gameplay sequencer: score, health, hit/coin arbitration, TITLE/PLAY/INVULN/GAME_OVER
// Optional health regeneration is enabled with `define GFC_HEALTH_REGEN_EN.
module game_flow_ctrl
    import gfc_pkg::*;
#(
    parameter int N_ENEMY       = 4,
    parameter int MAX_HEALTH    = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int REGEN_FRAMES  = 180
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_frame_tick,
    input  logic               i_start_btn,
    input  logic [N_ENEMY-1:0] i_hit_req,
    output logic [N_ENEMY-1:0] o_hit_ack,
    input  logic               i_coin_req,
    output logic               o_coin_ack,
    output logic [3:0]         o_score1,
    output logic [3:0]         o_score2,
    output logic [1:0]         o_health,
    output logic [1:0]         o_state,
    output logic               o_invuln
);

    localparam int PW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;

    gfc_state_t         r_state;
    bcd_t               r_score1;
    bcd_t               r_score2;
    logic [1:0]         r_health;
    logic [N_ENEMY-1:0] r_hit_ack;
    logic               r_coin_ack;
    logic [PW-1:0]      r_rr_ptr;
    logic [7:0]         r_inv_cnt;

    logic [N_ENEMY-1:0] w_grant;
    logic               w_grant_valid;
    logic [PW-1:0]      w_grant_idx;
    logic [PW-1:0]      w_next_ptr;
    logic [7:0]         w_score_inc;

`ifdef GFC_HEALTH_REGEN_EN
    localparam int RW = (REGEN_FRAMES > 1) ? $clog2(REGEN_FRAMES) : 1;
    logic [RW-1:0] r_regen_cnt;
`else
    logic w_unused_regen;
    assign w_unused_regen = ^REGEN_FRAMES;
`endif

    rr_arbiter #(
        .N  (N_ENEMY),
        .PW (PW)
    ) u_arb (
        .i_req   (i_hit_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_valid (w_grant_valid),
        .o_idx   (w_grant_idx)
    );

    assign w_next_ptr  = (w_grant_idx == PW'(N_ENEMY - 1)) ? '0 : w_grant_idx + PW'(1);
    assign w_score_inc = bcd2_inc(r_score2, r_score1);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= TITLE;
            r_score1   <= '0;
            r_score2   <= '0;
            r_health   <= 2'(MAX_HEALTH);
            r_hit_ack  <= '0;
            r_coin_ack <= 1'b0;
            r_rr_ptr   <= '0;
            r_inv_cnt  <= '0;
`ifdef GFC_HEALTH_REGEN_EN
            r_regen_cnt <= '0;
`endif
        end else begin
            r_hit_ack  <= '0;
            r_coin_ack <= 1'b0;
            if (i_frame_tick) begin
                case (r_state)
                    TITLE: begin
                        if (i_start_btn) begin
                            r_state  <= PLAY;
                            r_score1 <= '0;
                            r_score2 <= '0;
                            r_health <= 2'(MAX_HEALTH);
`ifdef GFC_HEALTH_REGEN_EN
                            r_regen_cnt <= '0;
`endif
                        end
                    end
                    PLAY: begin
                        // The coin is banked even when the same frame's hit is fatal.
                        if (i_coin_req) begin
                            r_coin_ack           <= 1'b1;
                            {r_score2, r_score1} <= w_score_inc;
                        end
                        if (w_grant_valid) begin
                            r_hit_ack <= w_grant;
                            r_rr_ptr  <= w_next_ptr;
                            if (r_health <= 2'd1) begin
                                r_health <= 2'd0;
                                r_state  <= GAME_OVER;
                            end else begin
                                r_health  <= r_health - 2'd1;
                                r_state   <= INVULN;
                                r_inv_cnt <= 8'(INVULN_FRAMES - 1);
                            end
                        end
`ifdef GFC_HEALTH_REGEN_EN
                        if (w_grant_valid) begin
                            r_regen_cnt <= '0;
                        end else if (r_regen_cnt == RW'(REGEN_FRAMES - 1)) begin
                            if (r_health < 2'(MAX_HEALTH)) begin
                                r_health    <= r_health + 2'd1;
                                r_regen_cnt <= '0;
                            end
                        end else begin
                            r_regen_cnt <= r_regen_cnt + RW'(1);
                        end
`endif
                    end
                    INVULN: begin
                        r_hit_ack <= i_hit_req;
                        if (i_coin_req) begin
                            r_coin_ack           <= 1'b1;
                            {r_score2, r_score1} <= w_score_inc;
                        end
                        if (r_inv_cnt == 8'd0) begin
                            r_state <= PLAY;
                        end else begin
                            r_inv_cnt <= r_inv_cnt - 8'd1;
                        end
                    end
                    GAME_OVER: begin
                        if (i_start_btn) begin
                            r_state <= TITLE;
                        end
                    end
                    default: r_state <= TITLE;
                endcase
            end
        end
    end

    assign o_hit_ack  = r_hit_ack;
    assign o_coin_ack = r_coin_ack;
    assign o_score1   = r_score1;
    assign o_score2   = r_score2;
    assign o_health   = r_health;
    assign o_state    = r_state;
    assign o_invuln   = (r_state == INVULN);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - self-checking bench: decimal-score reference model plus directed literal checks
module tb_game_flow_ctrl;

    localparam int N   = 4;
    localparam int MXH = 3;
    localparam int INV = 60;
    localparam int RGN = 180;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tick = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] hit_req = '0;
    logic         coin_req = 1'b0;
    logic [N-1:0] hit_ack;
    logic         coin_ack;
    logic [3:0]   score1;
    logic [3:0]   score2;
    logic [1:0]   health;
    logic [1:0]   state;
    logic         invuln;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    bit done     = 1'b0;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .N_ENEMY       (N),
        .MAX_HEALTH    (MXH),
        .INVULN_FRAMES (INV),
        .REGEN_FRAMES  (RGN)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_frame_tick (tick),
        .i_start_btn  (start),
        .i_hit_req    (hit_req),
        .o_hit_ack    (hit_ack),
        .i_coin_req   (coin_req),
        .o_coin_ack   (coin_ack),
        .o_score1     (score1),
        .o_score2     (score2),
        .o_health     (health),
        .o_state      (state),
        .o_invuln     (invuln)
    );

    // Reference model: states as 0..3, score as a plain 0..99 integer.
    int e_state, e_score, e_health, e_ptr, e_inv, e_regen, e_hit_ack, e_coin_ack;

    always @(posedge clk) begin
        e_hit_ack  = 0;
        e_coin_ack = 0;
        if (!rst) begin
            e_state = 0; e_score = 0; e_health = MXH; e_ptr = 0; e_inv = 0; e_regen = 0;
        end else if (tick) begin
            case (e_state)
                0: if (start) begin e_state = 1; e_score = 0; e_health = MXH; e_regen = 0; end
                1: begin
                    if (coin_req) begin e_coin_ack = 1; if (e_score < 99) e_score++; end
                    if (hit_req != 0) begin
                        for (int j = 0; j < N; j++) begin
                            int g;
                            g = (e_ptr + j) % N;
                            if (hit_req[g] && e_hit_ack == 0) e_hit_ack = 1 << g;
                        end
                        for (int g = 0; g < N; g++) if (e_hit_ack == (1 << g)) e_ptr = (g + 1) % N;
                        e_health = e_health - 1;
                        e_regen  = 0;
                        if (e_health == 0) e_state = 3;
                        else begin e_state = 2; e_inv = INV - 1; end
                    end
`ifdef GFC_HEALTH_REGEN_EN
                    else if (e_regen == RGN - 1) begin
                        if (e_health < MXH) begin e_health++; e_regen = 0; end
                    end else e_regen++;
`endif
                end
                2: begin
                    e_hit_ack = int'(hit_req);
                    if (coin_req) begin e_coin_ack = 1; if (e_score < 99) e_score++; end
                    if (e_inv == 0) e_state = 1; else e_inv--;
                end
                default: if (start) e_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [17:0] act, exp;
            act = {state, score2, score1, health, hit_ack, coin_ack, invuln};
            exp = {2'(e_state), 4'(e_score / 10), 4'(e_score % 10), 2'(e_health),
                   N'(e_hit_ack), 1'(e_coin_ack), (e_state == 2)};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One frame tick: returns one time unit after the updating edge.
    task automatic tick_only;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic gap;
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin tick_only(); gap(); end
    endtask

    task automatic coins(input int n);
        for (int k = 0; k < n; k++) begin coin_req = 1'b1; tick_only(); coin_req = 1'b0; gap(); end
    endtask

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog actual=timeout required=finish");
            $fatal(1, "watchdog");
        end
    end

    initial begin
        // Reset, including a frame tick with start held during reset.
        rst = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        tick_only();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_score", 32'({score2, score1}), 32'h00);
        chk("reset_health", 32'(health), 32'd3);
        chk("reset_acks", 32'({hit_ack, coin_ack}), 32'd0);
        rst = 1'b1; start = 1'b0;
        gap();

        // Start with pending hits: TITLE does not ack them.
        hit_req = 4'b1010; start = 1'b1;
        tick_only();
        chk("start_state", 32'(state), 32'd1);
        chk("start_no_ack", 32'(hit_ack), 32'd0);
        start = 1'b0; gap();

        tick_only();
        chk("hit1_ack", 32'(hit_ack), 32'b0010);
        chk("hit1_health", 32'(health), 32'd2);
        chk("hit1_invuln", 32'({state, invuln}), 32'b101);
        gap();
        chk("hit1_ack_clears", 32'(hit_ack), 32'd0);

        hit_req = 4'b1111;
        tick_only();
        chk("invuln_ack_all", 32'(hit_ack), 32'b1111);
        chk("invuln_health", 32'(health), 32'd2);
        hit_req = '0; gap();
        ticks(58);
        chk("invuln_still", 32'(state), 32'd2);
        ticks(1);
        chk("invuln_done", 32'({state, invuln}), 32'b010);

        coins(9);
        chk("score_09", 32'({score2, score1}), 32'h09);
        coin_req = 1'b1; tick_only(); coin_req = 1'b0;
        chk("score_carry", 32'({score2, score1, 3'b0, coin_ack}), 32'h101);
        gap();

        hit_req = 4'b1001;
        tick_only();
        chk("rr_grant_bit3", 32'(hit_ack), 32'b1000);
        chk("hit2_health", 32'(health), 32'd1);
        hit_req = '0; gap();
        ticks(60);

        hit_req = 4'b0001; coin_req = 1'b1;
        tick_only();
        chk("fatal_state", 32'(state), 32'd3);
        chk("fatal_health", 32'(health), 32'd0);
        chk("fatal_coin", 32'({score2, score1, 3'b0, coin_ack}), 32'h111);
        gap();
        hit_req = 4'b1111;
        tick_only();
        chk("gameover_frozen", 32'({hit_ack, coin_ack, score2, score1}), 32'h011);
        hit_req = '0; coin_req = 1'b0; gap();

        start = 1'b1;
        tick_only();
        chk("gameover_to_title", 32'(state), 32'd0);
        gap();
        tick_only();
        chk("restart", 32'({state, health, score2, score1}), 32'h700);
        start = 1'b0; gap();

        coins(99);
        chk("score_99", 32'({score2, score1}), 32'h99);
        coin_req = 1'b1; tick_only(); coin_req = 1'b0;
        chk("score_saturate", 32'({score2, score1, 3'b0, coin_ack}), 32'h991);
        gap();

        hit_req = 4'b0010;
        tick_only();
        chk("rr_after_wrap", 32'(hit_ack), 32'b0010);
        hit_req = '0; gap();
        ticks(5);
        rst = 1'b0; hit_req = 4'b1111; coin_req = 1'b1;
        tick_only();
        chk("midinv_reset", 32'({state, health, score2, score1}), 32'h300);
        chk("midinv_no_ack", 32'({hit_ack, coin_ack}), 32'd0);
        rst = 1'b1; hit_req = '0; coin_req = 1'b0; gap();

`ifdef GFC_HEALTH_REGEN_EN
        start = 1'b1; tick_only(); start = 1'b0; gap();
        hit_req = 4'b0001; tick_only(); hit_req = '0; gap();
        ticks(60);
        ticks(179);
        chk("regen_not_yet", 32'(health), 32'd2);
        ticks(1);
        chk("regen_plus1", 32'(health), 32'd3);
`endif

        gap();
        chk_en = 1'b0;
        done   = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
